// File: rtl/cc_forward_unit.sv
// NZP condition-code source for the branch in decode: architectural CC register plus
// EX/MEM shadow slots of CC-setting instructions with youngest-first forwarding.
module cc_forward_unit #(
  parameter logic [2:0] RESET_CC    = 3'b010,
  parameter int         STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic                   id_sets_cc,
  input  logic [15:0]            ex_result,
  input  logic                   ex_res_ok,
  input  logic [15:0]            mem_result,
  input  logic                   mem_res_ok,
  output logic [2:0]             nzp_out,
  output logic                   nzp_ready,
  output logic [2:0]             cc_reg,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic ex_v;
  logic ex_cc;
  logic mem_v;
  logic mem_cc;

  function automatic logic [2:0] gen(input logic [15:0] x);
    if (x[15])              return 3'b100;
    else if (x == 16'h0000) return 3'b010;
    else                    return 3'b001;
  endfunction

  // Only valid/sets-cc flags are tracked; result values always come from the live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_reg <= RESET_CC;
      ex_v   <= 1'b0;
      ex_cc  <= 1'b0;
      mem_v  <= 1'b0;
      mem_cc <= 1'b0;
    end else if (advance) begin
      if (mem_v && mem_cc)
        cc_reg <= gen(mem_result);
      mem_v  <= ex_v;
      mem_cc <= ex_cc;
      ex_v   <= id_valid & ~flush;
      ex_cc  <= id_sets_cc & ~flush;
    end else if (flush) begin
      ex_v  <= 1'b0;
      ex_cc <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (id_valid && !nzp_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  // The youngest producer decides readiness; an older ready one never bypasses it.
  always_comb begin
    nzp_out   = cc_reg;
    nzp_ready = 1'b1;
    if (ex_v && ex_cc) begin
      nzp_out   = gen(ex_result);
      nzp_ready = ex_res_ok;
    end else if (mem_v && mem_cc) begin
      nzp_out   = gen(mem_result);
      nzp_ready = mem_res_ok;
    end
  end

endmodule

// File: tb/tb_cc_forward_unit.sv
// Scoreboard bench for cc_forward_unit: an in-flight instruction list model predicts
// outputs per cycle, a negedge monitor compares; directed scenarios then random traffic.
module tb_cc_forward_unit;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        flush;
  logic        id_valid;
  logic        id_sets_cc;
  logic [15:0] ex_result;
  logic        ex_res_ok;
  logic [15:0] mem_result;
  logic        mem_res_ok;
  logic [2:0]  nzp_out;
  logic        nzp_ready;
  logic [2:0]  cc_reg;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  cc_forward_unit #(.RESET_CC(3'b010), .STALL_CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_sets_cc (id_sets_cc),
    .ex_result  (ex_result),
    .ex_res_ok  (ex_res_ok),
    .mem_result (mem_result),
    .mem_res_ok (mem_res_ok),
    .nzp_out    (nzp_out),
    .nzp_ready  (nzp_ready),
    .cc_reg     (cc_reg),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what sits in the EX and MEM stages, as a two-entry list of instructions.
  typedef struct {
    bit valid;
    bit setsCc;
  } instr_t;

  typedef struct {
    logic [2:0]  nzp;
    bit          ready;
    logic [2:0]  cc;
    logic [15:0] stall;
  } exp_t;

  instr_t inFlight[2];
  logic [2:0] modelCc;
  int modelStall;
  bit modelKnown = 0;
  exp_t expQ[$];

  function automatic logic [2:0] nzpOf(input logic [15:0] x);
    if ($signed(x) < 0) return 3'b100;
    if (x == 0)         return 3'b010;
    return 3'b001;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.nzp   = modelCc;
    e.ready = 1;
    e.cc    = modelCc;
    e.stall = 16'(modelStall);
    if (inFlight[0].valid && inFlight[0].setsCc) begin
      e.nzp   = nzpOf(ex_result);
      e.ready = ex_res_ok;
    end else if (inFlight[1].valid && inFlight[1].setsCc) begin
      e.nzp   = nzpOf(mem_result);
      e.ready = mem_res_ok;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs the model expects for this cycle.
  task automatic applyStimulus(input bit r, input bit adv, input bit fl, input bit iv,
                               input bit isc, input logic [15:0] exr, input bit exok,
                               input logic [15:0] memr, input bit memok);
    rst = r; advance = adv; flush = fl; id_valid = iv; id_sets_cc = isc;
    ex_result = exr; ex_res_ok = exok; mem_result = memr; mem_res_ok = memok;
    assert (!(modelKnown && !r && adv && inFlight[1].valid && inFlight[1].setsCc && !memok))
      else $error("[TB] commit issued while load data not returned");
    if (modelKnown) expQ.push_back(predict());
  endtask

  // Advance one clock and move the model forward with the inputs that were applied.
  task automatic tick();
    exp_t e;
    if (modelKnown) e = predict();
    @(posedge clk);
    #1;
    if (rst) begin
      modelCc    = 3'b010;
      inFlight[0] = '{0, 0};
      inFlight[1] = '{0, 0};
      modelStall = 0;
      modelKnown = 1;
    end else if (modelKnown) begin
      if (id_valid && !e.ready && modelStall < 65535) modelStall++;
      if (advance) begin
        if (inFlight[1].valid && inFlight[1].setsCc) modelCc = nzpOf(mem_result);
        inFlight[1] = inFlight[0];
        inFlight[0] = flush ? '{0, 0} : '{id_valid, id_sets_cc};
      end else if (flush) begin
        inFlight[0] = '{0, 0};
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("nzp_ready", nzp_ready, e.ready);
      checkOutput("nzp_onehot", $onehot(nzp_out), 1);
      if (e.ready) checkOutput("nzp_out", nzp_out, e.nzp);
      checkOutput("cc_reg", cc_reg, e.cc);
      checkOutput("stall_cnt", stall_cnt, e.stall);
    end
  end

  initial begin
    logic [15:0] pick [4];
    logic [15:0] exr;
    logic [15:0] memr;
    bit adv;
    bit memok;

    applyStimulus(1, 0, 0, 0, 0, 16'h0, 1, 16'h0, 1);
    tick();
    // Test 1: idle after reset.
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 16'h0, 1);
    #1;
    checkOutput("reset_cc", cc_reg, 3'b010);
    checkOutput("reset_nzp", nzp_out, 3'b010);
    checkOutput("reset_ready", nzp_ready, 1);
    checkOutput("reset_stall", stall_cnt, 0);
    tick();

    // Test 2: ADD producing 16'h8000 forwards N from EX, then commits.
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h8000, 1, 16'h0, 1);
    #1;
    checkOutput("ex_fwd_nzp", nzp_out, 3'b100);
    checkOutput("ex_fwd_ready", nzp_ready, 1);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 16'h8000, 1, 16'h0, 1);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 16'h0, 1, 16'h8000, 1);
    tick();
    checkOutput("commit_cc", cc_reg, 3'b100);

    // Test 3: load in EX then MEM stalls the branch until data returns.
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    repeat (2) begin
      applyStimulus(0, 0, 0, 1, 0, 16'h1234, 0, 16'h0, 1);
      tick();
    end
    checkOutput("load_stall_cnt", stall_cnt, 2);
    applyStimulus(0, 1, 0, 0, 0, 16'h1234, 0, 16'h0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h0, 1, 16'h7777, 0);
    #1;
    checkOutput("mem_notready", nzp_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h0, 1, 16'h0000, 1);
    #1;
    checkOutput("mem_fwd_nzp", nzp_out, 3'b010);
    checkOutput("mem_fwd_ready", nzp_ready, 1);
    tick();

    // Test 4: back-to-back producers, EX is youngest and wins.
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 1, 16'h0005, 1);
    #1;
    checkOutput("ex_wins_nzp", nzp_out, 3'b010);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0005, 1);
    #1;
    checkOutput("no_fallthrough", nzp_ready, 0);
    tick();

    // Test 5: redirect squashes the CC-setting ID instruction while MEM commits.
    applyStimulus(0, 1, 1, 1, 1, 16'h0000, 1, 16'h0005, 1);
    tick();
    checkOutput("flush_commit_cc", cc_reg, 3'b001);
    applyStimulus(0, 1, 0, 0, 0, 16'h0, 1, 16'h0000, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h8000, 0, 16'h8000, 0);
    #1;
    checkOutput("from_cc_nzp", nzp_out, 3'b010);
    checkOutput("from_cc_ready", nzp_ready, 1);
    tick();

    // Test 6: reset mid-stall with both slots occupied, then counter saturation.
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 0, 16'h0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 16'h0, 0, 16'h0, 1);
    tick();
    applyStimulus(1, 1, 1, 1, 1, 16'h0, 0, 16'h0, 0);
    tick();
    checkOutput("midrst_cc", cc_reg, 3'b010);
    checkOutput("midrst_stall", stall_cnt, 0);
    applyStimulus(0, 0, 0, 1, 0, 16'h8000, 0, 16'h8000, 0);
    #1;
    checkOutput("midrst_ready", nzp_ready, 1);
    tick();
    applyStimulus(0, 1, 0, 1, 1, 16'h0, 1, 16'h0, 1);
    tick();
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 16'h0, 0, 16'h0, 1);
      tick();
    end
    checkOutput("stall_saturate", stall_cnt, 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 1, 16'h0, 1);
    tick();

    // Random traffic; commits only happen once load data is back.
    pick[0] = 16'h0000; pick[1] = 16'h8000; pick[2] = 16'hFFFF; pick[3] = 16'h0001;
    for (int i = 0; i < 3000; i++) begin
      exr   = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      memr  = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      adv   = ($urandom_range(0, 2) != 0);
      memok = ($urandom_range(0, 3) != 0);
      if (adv && inFlight[1].valid && inFlight[1].setsCc) memok = 1;
      applyStimulus(($urandom_range(0, 199) == 0), adv, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 1), $urandom_range(0, 1), exr,
                    ($urandom_range(0, 2) != 0), memr, memok);
      tick();
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
